// File: rtl/hack_pkg.sv
// Shared definitions for the Hack RAM4 building block: word width, bank depth
// and the clear-sweep FSM state encoding.
package hack_pkg;

  localparam int WORD_W     = 16;
  localparam int BANK_DEPTH = 4;
  localparam int ADDR_W     = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg4_bank_mux4way16.sv
// Hack 4-way 16-bit selector: out = a/b/c/d for sel = 0/1/2/3.
import hack_pkg::*;

module mux4way16 (
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic [WORD_W-1:0] c_i,
  input  logic [WORD_W-1:0] d_i,
  input  logic [1:0]        sel_i,
  output logic [WORD_W-1:0] out_o
);

  // Pure combinational select, no storage.
  always_comb begin
    out_o = a_i;
    case (sel_i)
      2'd0: out_o = a_i;
      2'd1: out_o = b_i;
      2'd2: out_o = c_i;
      2'd3: out_o = d_i;
      default: out_o = a_i;
    endcase
  end

endmodule

// File: rtl/reg4_bank.sv
// Four-word register bank (Hack RAM4) with a valid/ready write port, a
// four-cycle clear sweep, per-word valid tracking and a wrapping write count.
//
// Write handshake: a write is accepted at a rising edge when
// wr_valid & wr_ready are both high. wr_ready is low only while the clear
// sweep runs; the requester holds wr_valid/wr_addr/wr_data stable until
// it is accepted. Reads are combinational with no write bypass.
import hack_pkg::*;

module reg4_bank #(
  parameter int WIDTH = 16,  // only 16 is legal: the read path is mux4way16
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [1:0]        rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic [3:0]        valid_mask,
  output logic [CNT_W-1:0]  wr_count,
  output state_t            dbg_state
);

  logic [WIDTH-1:0]      mem_q [BANK_DEPTH];
  logic [WIDTH-1:0]      mem_d [BANK_DEPTH];
  logic [BANK_DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic                  wr_fire;

  assign busy       = (state_q == ST_CLEAR);
  assign wr_ready   = !busy;
  assign wr_fire    = wr_valid & wr_ready;
  assign valid_mask = valid_q;
  assign wr_count   = cnt_q;
  assign rd_valid   = valid_q[rd_addr];
  assign dbg_state  = state_q;

  // Read path: Hack selector over the four stored words.
  mux4way16 u_rd_mux (
    .a_i   (mem_q[0]),
    .b_i   (mem_q[1]),
    .c_i   (mem_q[2]),
    .d_i   (mem_q[3]),
    .sel_i (rd_addr),
    .out_o (rd_data)
  );

  // Next state: accepted write commits first; a sweep step clears one word per cycle.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    idx_d   = idx_q;

    // Writes can only fire in IDLE, so they never collide with a sweep step.
    if (wr_fire) begin
      mem_d[wr_addr]   = wr_data;
      valid_d[wr_addr] = 1'b1;
      cnt_d            = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // Level-sensitive: a held clr_req restarts a sweep after each one ends.
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        // clr_req is ignored here; the sweep always runs exactly four cycles.
        mem_d[idx_q]   = '0;
        valid_d[idx_q] = 1'b0;
        idx_d          = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(BANK_DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any sweep and wipes all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_reg4_bank.sv
// Bench for reg4_bank: directed vector table plus hand-written sequences for
// the clear sweep corners, mid-sweep reset and the write-counter wrap.
import hack_pkg::*;

module tb_reg4_bank;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        clr_req = 1'b0;
  logic        busy;
  logic [3:0]  valid_mask;
  logic [15:0] wr_count;
  state_t      dbg_state;

  always #5 clk = ~clk;

  reg4_bank #(.WIDTH(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clr_req    (clr_req),
    .busy       (busy),
    .valid_mask (valid_mask),
    .wr_count   (wr_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  logic [15:0] mdl_mem [4];
  logic [3:0]  mdl_mask;
  logic [15:0] mdl_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a write until accepted, with a bounded wait.
  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    int n;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 20) begin
      tick();
      n++;
    end
    check("write_ready_wait", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      check($sformatf("%s rd_data[%0d]", tag, a), {16'd0, rd_data}, 32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wv;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic [1:0]  ra;
    logic        clr;
    logic [15:0] e_rd;
    logic        e_rv;
    logic [3:0]  e_mask;
    logic [15:0] e_cnt;
    logic        e_busy;
    logic        e_ready;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  // Watchdog so the run always terminates.
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Each row: inputs applied for one cycle, expectations after the edge.
    //            wv    wa    wd        ra    clr   e_rd      rv    mask     cnt    busy  ready
    vecs[0]  = '{1'b1, 2'd0, 16'h1234, 2'd0, 1'b0, 16'h1234, 1'b1, 4'b0001, 16'd1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 2'd1, 16'hABCD, 2'd0, 1'b0, 16'h1234, 1'b1, 4'b0011, 16'd2, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 2'd2, 16'h00FF, 2'd1, 1'b0, 16'hABCD, 1'b1, 4'b0111, 16'd3, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 2'd3, 16'hFFFF, 2'd2, 1'b0, 16'h00FF, 1'b1, 4'b1111, 16'd4, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 16'h0000, 2'd3, 1'b0, 16'hFFFF, 1'b1, 4'b1111, 16'd4, 1'b0, 1'b1};
    // clear pulse with full bank; write held during the sweep
    vecs[5]  = '{1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 16'h1234, 1'b1, 4'b1111, 16'd4, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 2'd1, 16'h7777, 2'd0, 1'b0, 16'h0000, 1'b0, 4'b1110, 16'd4, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 16'h7777, 2'd1, 1'b0, 16'h0000, 1'b0, 4'b1100, 16'd4, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 16'h7777, 2'd2, 1'b0, 16'h0000, 1'b0, 4'b1000, 16'd4, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 16'h7777, 2'd3, 1'b0, 16'h0000, 1'b0, 4'b0000, 16'd4, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 2'd1, 16'h7777, 2'd1, 1'b0, 16'h7777, 1'b1, 4'b0010, 16'd5, 1'b0, 1'b1};
    // clr_req and a write in the same IDLE cycle
    vecs[11] = '{1'b1, 2'd3, 16'h4242, 2'd3, 1'b1, 16'h4242, 1'b1, 4'b1010, 16'd6, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 16'h0000, 2'd3, 1'b0, 16'h4242, 1'b1, 4'b1010, 16'd6, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 16'h0000, 2'd1, 1'b0, 16'h0000, 1'b0, 4'b1000, 16'd6, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 16'h0000, 2'd3, 1'b0, 16'h4242, 1'b1, 4'b1000, 16'd6, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 2'd0, 16'h0000, 2'd3, 1'b0, 16'h0000, 1'b0, 4'b0000, 16'd6, 1'b0, 1'b1};

    // ---- reset ----
    #23;
    check("reset valid_mask", {28'd0, valid_mask}, 32'd0);
    check("reset wr_count", {16'd0, wr_count}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("reset wr_ready", {31'd0, wr_ready}, 32'd1);

    // ---- vector table ----
    for (int i = 0; i < NV; i++) begin
      wr_valid = vecs[i].wv;
      wr_addr  = vecs[i].wa;
      wr_data  = vecs[i].wd;
      rd_addr  = vecs[i].ra;
      clr_req  = vecs[i].clr;
      tick();
      check($sformatf("v%0d rd_data", i),  {16'd0, rd_data},    {16'd0, vecs[i].e_rd});
      check($sformatf("v%0d rd_valid", i), {31'd0, rd_valid},   {31'd0, vecs[i].e_rv});
      check($sformatf("v%0d mask", i),     {28'd0, valid_mask}, {28'd0, vecs[i].e_mask});
      check($sformatf("v%0d count", i),    {16'd0, wr_count},   {16'd0, vecs[i].e_cnt});
      check($sformatf("v%0d busy", i),     {31'd0, busy},       {31'd0, vecs[i].e_busy});
      check($sformatf("v%0d ready", i),    {31'd0, wr_ready},   {31'd0, vecs[i].e_ready});
      check($sformatf("v%0d state", i),    {31'd0, dbg_state},  {31'd0, vecs[i].e_busy});
    end
    wr_valid = 1'b0;
    clr_req  = 1'b0;

    // ---- clr_req held across a sweep: back-to-back sweeps ----
    do_write(2'd0, 16'h0101);
    do_write(2'd1, 16'h0202);
    do_write(2'd2, 16'h0303);
    do_write(2'd3, 16'h0404);
    check("refill mask", {28'd0, valid_mask}, 32'h0000_000F);
    check("refill count", {16'd0, wr_count}, 32'd10);
    exp_q = {16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0};
    clr_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 5) clr_req = 1'b0;
      check($sformatf("held_clr busy k%0d", k), {31'd0, busy}, {16'd0, exp_q.pop_front()});
    end
    check("held_clr mask", {28'd0, valid_mask}, 32'd0);
    check("held_clr count", {16'd0, wr_count}, 32'd10);
    check_all_zero("held_clr");

    // ---- same-cycle write and read to one address: no bypass ----
    do_write(2'd2, 16'h00FF);
    wr_valid = 1'b1;
    wr_addr  = 2'd2;
    wr_data  = 16'h5A5A;
    rd_addr  = 2'd2;
    #1;
    check("nobypass before edge", {16'd0, rd_data}, 32'h0000_00FF);
    tick();
    wr_valid = 1'b0;
    check("nobypass after edge", {16'd0, rd_data}, 32'h0000_5A5A);
    check("nobypass count", {16'd0, wr_count}, 32'd12);

    // ---- reset in the middle of a sweep ----
    do_write(2'd0, 16'h1111);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("midreset busy before", {31'd0, busy}, 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset mask", {28'd0, valid_mask}, 32'd0);
    check("midreset count", {16'd0, wr_count}, 32'd0);
    check_all_zero("midreset");
    #3;
    rst_n = 1'b1;
    tick();
    check("midreset ready", {31'd0, wr_ready}, 32'd1);
    do_write(2'd3, 16'hBEEF);
    rd_addr = 2'd3;
    #1;
    check("postreset rd_data", {16'd0, rd_data}, 32'h0000_BEEF);
    check("postreset mask", {28'd0, valid_mask}, 32'h0000_0008);
    check("postreset count", {16'd0, wr_count}, 32'd1);

    // ---- counter wrap with random writes against a model ----
    mdl_mem[0] = 16'h0; mdl_mem[1] = 16'h0; mdl_mem[2] = 16'h0; mdl_mem[3] = 16'hBEEF;
    mdl_mask = 4'b1000;
    mdl_cnt  = 16'd1;
    for (int i = 0; i < 65535; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 16'($urandom_range(0, 65535));
      if (i % 8192 == 0) check("wrap ready", {31'd0, wr_ready}, 32'd1);
      tick();
      mdl_mem[wr_addr] = wr_data;
      mdl_mask[wr_addr] = 1'b1;
      mdl_cnt = mdl_cnt + 16'd1;
      if (i % 8192 == 0 || i == 65534) begin
        for (int a = 0; a < 4; a++) begin
          rd_addr = 2'(a);
          #1;
          check($sformatf("wrap i%0d rd_data[%0d]", i, a), {16'd0, rd_data}, {16'd0, mdl_mem[a]});
          check($sformatf("wrap i%0d rd_valid[%0d]", i, a), {31'd0, rd_valid}, {31'd0, mdl_mask[a]});
        end
        check($sformatf("wrap i%0d count", i), {16'd0, wr_count}, {16'd0, mdl_cnt});
      end
    end
    wr_valid = 1'b0;
    check("wrap count zero", {16'd0, wr_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
